potential_fetch: RTL and testbench
==================================

# potential_fetch

Per-timestep membrane-potential reader for one neuron core. On a timestep start it sweeps every neuron index, issues reads to the synchronous potential memory (the memory the reset stage writes `potential_to_mem` into), and streams `(neuron id, potential)` pairs to the accumulate/adder stage over a valid/ready handshake. It forwards a same-cycle write-back so a freshly reset potential is never missed, and it absorbs downstream backpressure with a 2-entry buffer.

## Interface
Parameters:
- `NEURON_COUNT`, 64, neurons swept per timestep (≥2)
- `ADDR_W`, 6, memory address / neuron id width, `2**ADDR_W ≥ NEURON_COUNT`
- `DATA_W`, 32, potential width (IEEE-754 single)

Ports:
- `CLK` in 1: single clock, rising edge
- `RESET_N` in 1: reset is synchronous and active-low
- `TIMESTEP_START` in 1: one-cycle pulse that begins a sweep; ignored unless idle
- `MEM_RD_EN` out 1: memory read strobe
- `MEM_ADDR` out ADDR_W: read address
- `MEM_RD_DATA` in DATA_W: read data, valid the cycle after `MEM_RD_EN`; read-during-write returns old data
- `WB_EN` in 1: reset-stage write-back strobe, mirrors the memory write port
- `WB_ADDR` in ADDR_W: write-back address
- `WB_DATA` in DATA_W: write-back potential
- `OUT_VALID` out 1: output pair valid
- `OUT_READY` in 1: downstream accepts
- `OUT_NEURON_ID` out ADDR_W: neuron index
- `OUT_POTENTIAL` out DATA_W: potential
- `BUSY` out 1: high from the accepted start until `DONE`
- `DONE` out 1: one-cycle pulse at end of sweep

## Operation
- FSM states: IDLE, FETCH, DRAIN, FINISH.
- IDLE → FETCH on `TIMESTEP_START`. The read index clears to 0 and `BUSY` goes high.
- FETCH: issues a read at `MEM_ADDR`=index when `occupancy + inflight < 2`, then increments the index. After issuing `NEURON_COUNT-1` it goes to DRAIN, with no read past the last index.
- DRAIN: no reads. Exits to FINISH when the buffer is empty, nothing is in flight, and the last pair has been handshaked.
- FINISH: `DONE`=1 for one cycle, `BUSY`=0, then IDLE.
- Handshake: a transfer happens when `OUT_VALID && OUT_READY`. While `OUT_VALID` is high and not accepted, `OUT_NEURON_ID` and `OUT_POTENTIAL` hold stable. Pairs leave in ascending id order, each exactly once.
- Forwarding:
  - If `WB_EN && WB_ADDR==MEM_ADDR` in a read-issue cycle, register a hit flag and `WB_DATA`. The captured value is `WB_DATA` instead of `MEM_RD_DATA`.
  - A write-back in any other cycle is not forwarded; it belongs to the next timestep.
- Data is stored unmodified (no float arithmetic). Ids are zero-extended index values.
- `TIMESTEP_START` while not IDLE: ignored and not queued.
- Reset (`RESET_N`=0 at an edge), including mid-sweep:
  - FSM → IDLE, buffer flushed, in-flight read discarded, index = 0.
  - Outputs `MEM_RD_EN`=0, `MEM_ADDR`=0, `OUT_VALID`=0, `OUT_NEURON_ID`=0, `OUT_POTENTIAL`=0, `BUSY`=0, `DONE`=0.

## Timing
- Cycle 0: `TIMESTEP_START`=1 sampled.
- Cycle 1: `MEM_RD_EN`=1, `MEM_ADDR`=0.
- Cycle 2: `MEM_RD_DATA` presented; captured into the buffer at the end of cycle 2.
- Cycle 3: `OUT_VALID`=1 with id 0. Fetch-to-output latency is 2 cycles.
- With `OUT_READY` held high: one pair per cycle, no bubbles. The last pair (id `NEURON_COUNT-1`) is valid in cycle `NEURON_COUNT+2`, and `DONE` pulses in cycle `NEURON_COUNT+3`.
- Backpressure: reads stall so that at most 2 entries are ever held or in flight. No data is dropped; the full buffer does not overflow.
- A simultaneous push and pop on the buffer is allowed and keeps occupancy unchanged.
- Earliest next start: the cycle after `DONE`.

## Structure
- Shared package `neuron_pkg`: `DATA_W`/`ADDR_W` defaults, the `FP_ZERO` constant, and the FSM state enum (`PF_IDLE`, `PF_FETCH`, `PF_DRAIN`, `PF_FINISH`).
- One sub-module `skid_fifo2`: a 2-entry valid/ready buffer of width `ADDR_W+DATA_W`, with occupancy output, `full`/`empty`, and synchronous active-low reset.
- The top holds the FSM, index counter, in-flight flag, forwarding registers, and read-issue gating.

## Test plan
- Basic sweep: `NEURON_COUNT`=4, memory holds 0x40A00000, 0x3F800000, 0x00000000, 0xC0000000, `OUT_READY`=1 → ids 0..3 with those values in cycles 3..6, `DONE` in cycle 7, `BUSY` high in cycles 1..6.
- Backpressure: `OUT_READY` low in cycles 3..8 → id 0 held stable, `MEM_RD_EN` stalls after 2 outstanding, no loss or duplication, then in-order completion.
- Forwarding: memory[1]=0x40A00000, `WB_EN`=1, `WB_ADDR`=1, `WB_DATA`=0x00000000 in the cycle addr 1 is read → id 1 outputs 0x00000000. The same write one cycle later → id 1 outputs 0x40A00000.
- Restart ignored: a second `TIMESTEP_START` mid-sweep → no effect, exactly `NEURON_COUNT` pairs, one `DONE`.
- Mid-sweep reset: `RESET_N`=0 in cycle 5 → all outputs 0 next edge, buffer empty. A new start then sweeps from id 0 with correct data.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared defaults, constants and FSM encoding for the neuron core pipeline.
package neuron_pkg;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_FETCH,
    PF_DRAIN,
    PF_FINISH
  } pf_state_t;
endpackage

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready buffer with occupancy, full and empty; head is always slot0.
// Zero-latency head visibility after a push lands; a write while full and not popping is dropped.
module skid_fifo2 #(
  parameter int WIDTH = 38
) (
  input  logic             core_clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic [1:0]       occupancy,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             push;
  logic             pop;

  assign empty  = (occupancy == 2'd0);
  assign full   = (occupancy == 2'd2);
  assign rd_vld = !empty;
  assign rd_dat = slot0;
  assign pop    = rd_vld && rd_rdy;
  assign push   = wr_vld && (!full || pop);

  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      slot0     <= '0;
      slot1     <= '0;
      occupancy <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) slot0 <= wr_dat;
          else slot1 <= wr_dat;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          slot0     <= slot1;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy unchanged, queue shifts forward.
          if (occupancy == 2'd1) begin
            slot0 <= wr_dat;
          end else begin
            slot0 <= slot1;
            slot1 <= wr_dat;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/potential_fetch.sv
// Sweeps all neuron potentials per timestep and streams (id, potential) with write-back forwarding.
// Fetch-to-output latency 2 cycles; reads stall so at most 2 entries are ever buffered or in flight.
module potential_fetch
  import neuron_pkg::*;
#(
  parameter int NEURON_COUNT = 64,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              TIMESTEP_START,
  output logic              MEM_RD_EN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_RD_DATA,
  input  logic              WB_EN,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ADDR_W-1:0] OUT_NEURON_ID,
  output logic [DATA_W-1:0] OUT_POTENTIAL,
  output logic              BUSY,
  output logic              DONE
);
  localparam int                ENTRY_W  = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NEURON_COUNT - 1);

  pf_state_t           state;
  logic [ADDR_W-1:0]   index;
  logic                inflight;
  logic [ADDR_W-1:0]   inflight_id;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;
  logic                issue;
  logic                pop;
  logic [1:0]          occupancy;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  push_dat;
  logic [ENTRY_W-1:0]  head_dat;

  assign pop = OUT_VALID && OUT_READY;

  // Count the pop happening this cycle so a steady stream issues one read per cycle.
  assign issue = (state == PF_FETCH) &&
                 (inflight ? (fifo_empty || (occupancy == 2'd1 && pop))
                           : (!fifo_full || pop));

  assign MEM_RD_EN = issue;
  assign MEM_ADDR  = index;
  assign push_dat  = {inflight_id, (fwd_hit ? fwd_data : MEM_RD_DATA)};

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= PF_IDLE;
      index       <= '0;
      inflight    <= 1'b0;
      inflight_id <= '0;
      fwd_hit     <= 1'b0;
      fwd_data    <= DATA_W'(FP_ZERO);
    end else begin
      inflight <= issue;
      if (issue) begin
        // Memory returns pre-write data on a collision, so keep the fresh value.
        inflight_id <= index;
        fwd_hit     <= WB_EN && (WB_ADDR == index);
        fwd_data    <= WB_DATA;
      end
      case (state)
        PF_IDLE: begin
          if (TIMESTEP_START) begin
            state <= PF_FETCH;
            index <= '0;
          end
        end
        PF_FETCH: begin
          if (issue) begin
            if (index == LAST_IDX) state <= PF_DRAIN;
            else index <= index + ADDR_W'(1);
          end
        end
        PF_DRAIN: begin
          if (!inflight && (occupancy == {1'b0, pop})) state <= PF_FINISH;
        end
        PF_FINISH: begin
          state <= PF_IDLE;
          index <= '0;
        end
        default: state <= PF_IDLE;
      endcase
    end
  end

  skid_fifo2 #(
    .WIDTH(ENTRY_W)
  ) u_buf (
    .core_clk  (CLK),
    .rst_n     (RESET_N),
    .wr_vld    (inflight),
    .wr_dat    (push_dat),
    .rd_vld    (OUT_VALID),
    .rd_rdy    (OUT_READY),
    .rd_dat    (head_dat),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign OUT_NEURON_ID = head_dat[ENTRY_W-1:DATA_W];
  assign OUT_POTENTIAL = head_dat[DATA_W-1:0];
  assign BUSY          = (state == PF_FETCH) || (state == PF_DRAIN);
  assign DONE          = (state == PF_FINISH);
endmodule

// File: tb/tb_potential_fetch.sv
// Bench for potential_fetch: 4 neurons, 3-bit ids, behavioural memory and stream scoreboard.
module tb_potential_fetch;
  localparam int N = 4;

  logic        CLK;
  logic        RESET_N;
  logic        TIMESTEP_START;
  logic        MEM_RD_EN;
  logic [2:0]  MEM_ADDR;
  logic [31:0] MEM_RD_DATA;
  logic        WB_EN;
  logic [2:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [2:0]  OUT_NEURON_ID;
  logic [31:0] OUT_POTENTIAL;
  logic        BUSY;
  logic        DONE;

  potential_fetch #(.NEURON_COUNT(N), .ADDR_W(3), .DATA_W(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .TIMESTEP_START(TIMESTEP_START),
    .MEM_RD_EN(MEM_RD_EN), .MEM_ADDR(MEM_ADDR), .MEM_RD_DATA(MEM_RD_DATA),
    .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_NEURON_ID(OUT_NEURON_ID),
    .OUT_POTENTIAL(OUT_POTENTIAL), .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  // Environment: potential memory plus per-cycle observation log.
  logic [31:0] mem [8];
  logic        pend_rd = 1'b0;
  logic [31:0] pend_data = 32'h0;
  int          cyc;
  logic        s_rd_en [64];
  logic [2:0]  s_addr  [64];
  logic        s_valid [64];
  logic [2:0]  s_id    [64];
  logic [31:0] s_pot   [64];
  logic        s_busy  [64];
  logic        s_done  [64];
  int          rd_q[$];
  logic [2:0]  xfer_id[$];
  logic [31:0] xfer_pot[$];
  logic [31:0] snap [8];
  logic        snap_seen [8];
  int          done_cnt, hold_viol, issued, popped, max_out;
  logic        prev_hold = 1'b0;
  logic [2:0]  prev_id = 3'd0;
  logic [31:0] prev_pot = 32'h0;

  task automatic clear_obs();
    cyc = 0; rd_q.delete(); xfer_id.delete(); xfer_pot.delete();
    done_cnt = 0; hold_viol = 0; issued = 0; popped = 0; max_out = 0;
    for (int i = 0; i < 8; i++) snap_seen[i] = 1'b0;
  endtask

  task automatic step(input logic rst, input logic start, input logic ready,
                      input logic wen, input logic [2:0] waddr, input logic [31:0] wdata);
    int outstanding;
    @(negedge CLK);
    MEM_RD_DATA = pend_rd ? pend_data : 32'hBAD0_BAD0;
    RESET_N = rst; TIMESTEP_START = start; OUT_READY = ready;
    WB_EN = wen; WB_ADDR = waddr; WB_DATA = wdata;
    #1;
    if (cyc < 64) begin
      s_rd_en[cyc] = MEM_RD_EN; s_addr[cyc] = MEM_ADDR; s_valid[cyc] = OUT_VALID;
      s_id[cyc] = OUT_NEURON_ID; s_pot[cyc] = OUT_POTENTIAL;
      s_busy[cyc] = BUSY; s_done[cyc] = DONE;
    end
    if (rst) begin
      if (prev_hold && !(OUT_VALID && OUT_NEURON_ID == prev_id && OUT_POTENTIAL == prev_pot))
        hold_viol++;
      outstanding = issued + int'(MEM_RD_EN) - popped - int'(OUT_VALID && OUT_READY);
      if (outstanding > max_out) max_out = outstanding;
      if (MEM_RD_EN) begin rd_q.push_back(int'(MEM_ADDR)); issued++; end
      if (OUT_VALID && OUT_READY) begin
        xfer_id.push_back(OUT_NEURON_ID); xfer_pot.push_back(OUT_POTENTIAL); popped++;
      end
      if (DONE) done_cnt++;
      prev_hold = OUT_VALID && !OUT_READY; prev_id = OUT_NEURON_ID; prev_pot = OUT_POTENTIAL;
    end else begin
      prev_hold = 1'b0; issued = 0; popped = 0;
    end
    // Read returns old contents; a same-cycle write-back is what the fetch must report.
    pend_rd = MEM_RD_EN;
    pend_data = mem[MEM_ADDR];
    if (wen) mem[waddr] = wdata;
    if (MEM_RD_EN) begin snap[MEM_ADDR] = mem[MEM_ADDR]; snap_seen[MEM_ADDR] = 1'b1; end
    cyc++;
  endtask

  task automatic test_reset();
    clear_obs();
    step(0, 0, 0, 0, 3'd0, 32'h0);
    step(0, 1, 1, 1, 3'd2, 32'h1234_5678);
    checks++; if (s_rd_en[1] !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", s_rd_en[1]); end
    checks++; if (s_addr[1] !== 3'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", s_addr[1]); end
    checks++; if (s_valid[1] !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", s_valid[1]); end
    checks++; if (s_id[1] !== 3'd0) begin errors++; $display("FAIL reset_id got %0d want 0", s_id[1]); end
    checks++; if (s_pot[1] !== 32'h0) begin errors++; $display("FAIL reset_pot got %h want 0", s_pot[1]); end
    checks++; if (s_busy[1] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", s_busy[1]); end
    checks++; if (s_done[1] !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", s_done[1]); end
    step(1, 0, 1, 0, 3'd0, 32'h0);
    step(1, 0, 1, 0, 3'd0, 32'h0);
    checks++; if (s_busy[3] !== 1'b0 || s_rd_en[3] !== 1'b0)
      begin errors++; $display("FAIL reset_start_ignored busy %b rd_en %b want 0 0", s_busy[3], s_rd_en[3]); end
  endtask

  task automatic test_basic();
    logic [31:0] bv [4];
    logic exp;
    bv = '{32'h40A0_0000, 32'h3F80_0000, 32'h0000_0000, 32'hC000_0000};
    for (int i = 0; i < 4; i++) mem[i] = bv[i];
    clear_obs();
    step(1, 1, 1, 0, 3'd0, 32'h0);
    for (int c = 1; c <= 10; c++) step(1, 0, 1, 0, 3'd0, 32'h0);
    for (int c = 0; c <= 10; c++) begin
      exp = (c >= 1 && c <= 4);
      checks++; if (s_rd_en[c] !== exp) begin errors++; $display("FAIL basic_rd_en c%0d got %b want %b", c, s_rd_en[c], exp); end
      if (exp) begin
        checks++; if (s_addr[c] !== 3'(c - 1)) begin errors++; $display("FAIL basic_addr c%0d got %0d want %0d", c, s_addr[c], c - 1); end
      end
      exp = (c >= 3 && c <= 6);
      checks++; if (s_valid[c] !== exp) begin errors++; $display("FAIL basic_valid c%0d got %b want %b", c, s_valid[c], exp); end
      if (exp) begin
        checks++; if (s_id[c] !== 3'(c - 3) || s_pot[c] !== bv[c - 3])
          begin errors++; $display("FAIL basic_pair c%0d got %0d/%h want %0d/%h", c, s_id[c], s_pot[c], c - 3, bv[c - 3]); end
      end
      exp = (c >= 1 && c <= 6);
      checks++; if (s_busy[c] !== exp) begin errors++; $display("FAIL basic_busy c%0d got %b want %b", c, s_busy[c], exp); end
      exp = (c == 7);
      checks++; if (s_done[c] !== exp) begin errors++; $display("FAIL basic_done c%0d got %b want %b", c, s_done[c], exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bv [4];
    int nrd;
    for (int i = 0; i < 4; i++) begin bv[i] = $urandom; mem[i] = bv[i]; end
    clear_obs();
    step(1, 1, 1, 0, 3'd0, 32'h0);
    for (int c = 1; c <= 8; c++) step(1, 0, (c < 3), 0, 3'd0, 32'h0);
    for (int n = 0; n < 40 && done_cnt == 0; n++) step(1, 0, 1, 0, 3'd0, 32'h0);
    nrd = 0;
    for (int c = 1; c <= 8; c++) nrd += int'(s_rd_en[c]);
    checks++; if (nrd != 2) begin errors++; $display("FAIL bp_reads_before_release got %0d want 2", nrd); end
    for (int c = 3; c <= 8; c++) begin
      checks++; if (s_valid[c] !== 1'b1 || s_id[c] !== 3'd0 || s_pot[c] !== bv[0])
        begin errors++; $display("FAIL bp_hold c%0d got %b/%0d/%h want 1/0/%h", c, s_valid[c], s_id[c], s_pot[c], bv[0]); end
    end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold_viol got %0d want 0", hold_viol); end
    checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding got %0d want <=2", max_out); end
    checks++; if (xfer_id.size() != N) begin errors++; $display("FAIL bp_count got %0d want %0d", xfer_id.size(), N); end
    for (int i = 0; i < N && i < xfer_id.size(); i++) begin
      checks++; if (xfer_id[i] !== 3'(i) || xfer_pot[i] !== bv[i])
        begin errors++; $display("FAIL bp_pair %0d got %0d/%h want %0d/%h", i, xfer_id[i], xfer_pot[i], i, bv[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_forwarding();
    logic [31:0] bv [4];
    for (int pass = 0; pass < 2; pass++) begin
      bv = '{32'h1111_0000, 32'h40A0_0000, 32'h2222_0000, 32'h3333_0000};
      for (int i = 0; i < 4; i++) mem[i] = bv[i];
      // Write in the cycle id 1 is read is forwarded; one cycle later it is not.
      if (pass == 0) bv[1] = 32'h0000_0000;
      clear_obs();
      step(1, 1, 1, 0, 3'd0, 32'h0);
      for (int c = 1; c <= 12 && done_cnt == 0; c++)
        step(1, 0, 1, (c == 2 + pass), 3'd1, 32'h0000_0000);
      checks++; if (xfer_id.size() != N) begin errors++; $display("FAIL fwd%0d_count got %0d want %0d", pass, xfer_id.size(), N); end
      for (int i = 0; i < N && i < xfer_id.size(); i++) begin
        checks++; if (xfer_id[i] !== 3'(i) || xfer_pot[i] !== bv[i])
          begin errors++; $display("FAIL fwd%0d_pair %0d got %0d/%h want %0d/%h", pass, i, xfer_id[i], xfer_pot[i], i, bv[i]); end
      end
    end
  endtask

  task automatic test_restart_ignored();
    int late_busy;
    clear_obs();
    step(1, 1, 1, 0, 3'd0, 32'h0);
    for (int c = 1; c <= 13; c++) step(1, (c == 2 || c == 4 || c == 7), 1, 0, 3'd0, 32'h0);
    checks++; if (xfer_id.size() != N) begin errors++; $display("FAIL restart_count got %0d want %0d", xfer_id.size(), N); end
    for (int i = 0; i < N && i < xfer_id.size(); i++) begin
      checks++; if (xfer_id[i] !== 3'(i)) begin errors++; $display("FAIL restart_order %0d got %0d want %0d", i, xfer_id[i], i); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_cnt); end
    checks++; if (rd_q.size() != N) begin errors++; $display("FAIL restart_reads got %0d want %0d", rd_q.size(), N); end
    late_busy = 0;
    for (int c = 8; c <= 13; c++) late_busy += int'(s_busy[c]);
    checks++; if (late_busy != 0) begin errors++; $display("FAIL restart_after_done busy cycles %0d want 0", late_busy); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] bv [4];
    clear_obs();
    step(1, 1, 1, 0, 3'd0, 32'h0);
    for (int c = 1; c <= 4; c++) step(1, 0, 1, 0, 3'd0, 32'h0);
    step(0, 0, 1, 0, 3'd0, 32'h0);
    step(1, 0, 0, 0, 3'd0, 32'h0);
    checks++; if ({s_rd_en[6], s_valid[6], s_busy[6], s_done[6]} !== 4'b0000)
      begin errors++; $display("FAIL midrst_ctl got rd_en/valid/busy/done %b want 0000", {s_rd_en[6], s_valid[6], s_busy[6], s_done[6]}); end
    checks++; if (s_addr[6] !== 3'd0 || s_id[6] !== 3'd0 || s_pot[6] !== 32'h0)
      begin errors++; $display("FAIL midrst_data got %0d/%0d/%h want 0/0/0", s_addr[6], s_id[6], s_pot[6]); end
    step(1, 0, 1, 0, 3'd0, 32'h0);
    checks++; if (s_valid[7] !== 1'b0) begin errors++; $display("FAIL midrst_flushed got valid %b want 0", s_valid[7]); end
    for (int i = 0; i < 4; i++) begin bv[i] = $urandom; mem[i] = bv[i]; end
    clear_obs();
    step(1, 1, 1, 0, 3'd0, 32'h0);
    for (int n = 0; n < 60 && done_cnt == 0; n++) step(1, 0, ($urandom_range(0, 99) < 50), 0, 3'd0, 32'h0);
    checks++; if (xfer_id.size() != N) begin errors++; $display("FAIL midrst_count got %0d want %0d", xfer_id.size(), N); end
    for (int i = 0; i < N && i < xfer_id.size(); i++) begin
      checks++; if (xfer_id[i] !== 3'(i) || xfer_pot[i] !== bv[i])
        begin errors++; $display("FAIL midrst_pair %0d got %0d/%h want %0d/%h", i, xfer_id[i], xfer_pot[i], i, bv[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL midrst_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    for (int sw = 0; sw < 8; sw++) begin
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      clear_obs();
      step(1, 1, ($urandom_range(0, 99) < 60), 0, 3'd0, 32'h0);
      for (int n = 0; n < 200 && done_cnt == 0; n++)
        step(1, ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 60),
             ($urandom_range(0, 99) < 40), 3'($urandom_range(0, 7)), $urandom);
      checks++; if (rd_q.size() != N) begin errors++; $display("FAIL rnd%0d_reads got %0d want %0d", sw, rd_q.size(), N); end
      for (int i = 0; i < N && i < rd_q.size(); i++) begin
        checks++; if (rd_q[i] != i) begin errors++; $display("FAIL rnd%0d_rd_order %0d got %0d want %0d", sw, i, rd_q[i], i); end
      end
      checks++; if (xfer_id.size() != N) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", sw, xfer_id.size(), N); end
      for (int i = 0; i < N && i < xfer_id.size(); i++) begin
        checks++; if (xfer_id[i] !== 3'(i) || xfer_pot[i] !== snap[i] || !snap_seen[i])
          begin errors++; $display("FAIL rnd%0d_pair %0d got %0d/%h want %0d/%h", sw, i, xfer_id[i], xfer_pot[i], i, snap[i]); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done got %0d want 1", sw, done_cnt); end
      checks++; if (hold_viol != 0) begin errors++; $display("FAIL rnd%0d_hold got %0d want 0", sw, hold_viol); end
      checks++; if (max_out > 2) begin errors++; $display("FAIL rnd%0d_outstanding got %0d want <=2", sw, max_out); end
    end
  endtask

  initial begin
    RESET_N = 1'b0; TIMESTEP_START = 1'b0; OUT_READY = 1'b0;
    WB_EN = 1'b0; WB_ADDR = 3'd0; WB_DATA = 32'h0; MEM_RD_DATA = 32'h0;
    for (int i = 0; i < 8; i++) begin mem[i] = 32'h0; snap[i] = 32'h0; end
    test_reset();
    test_basic();
    test_backpressure();
    test_forwarding();
    test_restart_ignored();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
